// File: rtl/sdp_burst_rd.sv
// sdp_burst_rd
// Burst read sequencer that sits in front of the sdp RAM wrapper. A burst command
// {len, base} issues len+1 consecutive (DEPTH-wrapped) addresses on rd_addr. The
// returned words are forwarded on dout, with an end-of-transfer flag on the last word.
// The command is acknowledged in the same cycle as that last dout beat.
//
// Ports (valid/ready streams):
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_*                 consumer: data = {len[W_LEN], base[W_ADDR]}
//   rd_addr_*             producer: address to sdp
//   rd_data_*             consumer: word from sdp
//   dout_*                producer: data = {eot, word}
module sdp_burst_rd #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 16,
  parameter int W_LEN  = 8,
  parameter int DEPTH  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  input  logic [W_ADDR+W_LEN-1:0] cmd_data_i,
  output logic                    cmd_ready_o,
  output logic                    rd_addr_valid_o,
  output logic [W_ADDR-1:0]       rd_addr_data_o,
  input  logic                    rd_addr_ready_i,
  input  logic                    rd_data_valid_i,
  input  logic [W_DATA-1:0]       rd_data_data_i,
  output logic                    rd_data_ready_o,
  output logic                    dout_valid_o,
  output logic [W_DATA:0]         dout_data_o,
  input  logic                    dout_ready_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  localparam logic [W_ADDR:0] DEPTH_W = (W_ADDR+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [W_LEN:0]   iss_cnt_q, iss_cnt_d;
  logic [W_LEN-1:0] ret_cnt_q, ret_cnt_d;

  logic [W_ADDR-1:0] base;
  logic [W_LEN-1:0]  len;
  logic [W_ADDR:0]   addr_sum;
  logic [W_ADDR:0]   addr_wrap;
  logic              issuing, flowing, eot;
  logic              addr_hs, out_hs, done, iss_last;

  assign base = cmd_data_i[W_ADDR-1:0];
  assign len  = cmd_data_i[W_ADDR +: W_LEN];

  // IDLE with a pending command already issues its first address this cycle.
  assign issuing = !rst_i && ((state_q == ISSUE) || ((state_q == IDLE) && cmd_valid_i));
  assign flowing = !rst_i && (state_q != IDLE);

  // One extra bit so base + offset never overflows before the wrap compare.
  assign addr_sum  = {1'b0, base} + (W_ADDR+1)'(iss_cnt_q);
  assign addr_wrap = (addr_sum >= DEPTH_W) ? (addr_sum - DEPTH_W) : addr_sum;

  assign eot      = (ret_cnt_q == len);
  assign iss_last = (iss_cnt_q == {1'b0, len});
  assign addr_hs  = issuing && rd_addr_ready_i;
  assign out_hs   = flowing && rd_data_valid_i && dout_ready_i;
  assign done     = out_hs && eot;

  assign rd_addr_valid_o = issuing;
  assign rd_addr_data_o  = issuing ? addr_wrap[W_ADDR-1:0] : '0;
  assign rd_data_ready_o = flowing && dout_ready_i;
  assign dout_valid_o    = flowing && rd_data_valid_i;
  assign dout_data_o     = flowing ? {eot, rd_data_data_i} : '0;
  assign cmd_ready_o     = done;

  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (done) begin
      state_d   = IDLE;
      iss_cnt_d = '0;
      ret_cnt_d = '0;
    end else begin
      if (addr_hs) begin
        iss_cnt_d = iss_cnt_q + 1'b1;
      end
      if (addr_hs && iss_last) begin
        state_d = DRAIN;
      end else if ((state_q == IDLE) && cmd_valid_i) begin
        state_d = ISSUE;
      end
      if (out_hs) begin
        ret_cnt_d = ret_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

endmodule

// File: tb/tb_sdp_burst_rd.sv
// tb_sdp_burst_rd
// Directed bench for sdp_burst_rd with a small sdp model (one-cycle read latency,
// one output register, optional address stalls). DEPTH is 16 so wrap is reachable.
module tb_sdp_burst_rd;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [23:0] cmd_data;
  logic        cmd_ready;
  logic        rd_addr_valid;
  logic [15:0] rd_addr_data;
  logic        rd_addr_ready;
  logic        rd_data_valid;
  logic [15:0] rd_data_data;
  logic        rd_data_ready;
  logic        dout_valid;
  logic [16:0] dout_data;
  logic        dout_ready;
  logic        stall;
  logic        rnd_en = 1'b0;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  sdp_burst_rd #(.W_DATA(16), .W_ADDR(16), .W_LEN(8), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_data_i(cmd_data), .cmd_ready_o(cmd_ready),
    .rd_addr_valid_o(rd_addr_valid), .rd_addr_data_o(rd_addr_data), .rd_addr_ready_i(rd_addr_ready),
    .rd_data_valid_i(rd_data_valid), .rd_data_data_i(rd_data_data), .rd_data_ready_o(rd_data_ready),
    .dout_valid_o(dout_valid), .dout_data_o(dout_data), .dout_ready_i(dout_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_val(input int a);
    return 16'hC000 + 16'(a * 37);
  endfunction

  function automatic int exp_addr(input int base, input int i);
    return (base + i) % DEPTH;
  endfunction

  // sdp model
  logic        ov;
  logic [15:0] od;
  assign rd_addr_ready = (!ov || rd_data_ready) && !stall;
  assign rd_data_valid = ov;
  assign rd_data_data  = od;
  always @(posedge clk) begin
    if (rst) begin
      ov <= 1'b0;
      od <= '0;
    end else if (rd_addr_valid && rd_addr_ready) begin
      ov <= 1'b1;
      od <= mem_val(int'(rd_addr_data));
    end else if (rd_data_ready) begin
      ov <= 1'b0;
    end
  end

  // Downstream ready and sdp stall driver
  initial begin
    dout_ready = 1'b1;
    stall      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
        dout_ready = 1'($urandom_range(0, 1));
        stall      = 1'($urandom_range(0, 1));
      end else begin
        dout_ready = 1'b1;
        stall      = 1'b0;
      end
    end
  end

  // Handshake logger
  int          a_addr[$];
  int          a_cyc[$];
  logic [15:0] d_data[$];
  bit          d_eot[$];
  int          d_cyc[$];
  int          k_cyc[$];
  int          stab_err = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_addr_valid && rd_addr_ready) begin
        a_addr.push_back(int'(rd_addr_data));
        a_cyc.push_back(cyc);
      end
      if (dout_valid && dout_ready) begin
        d_data.push_back(dout_data[15:0]);
        d_eot.push_back(dout_data[16]);
        d_cyc.push_back(cyc);
      end
      if (cmd_ready) k_cyc.push_back(cyc);
      if (prev_stall && (!rd_addr_valid || rd_addr_data != prev_addr)) stab_err++;
      prev_stall = rd_addr_valid && !rd_addr_ready;
      prev_addr  = rd_addr_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && cmd_valid) assert (cmd_data[15:0] < 16'(DEPTH)) else $error("cmd base out of range");
  end

  task automatic clear_logs();
    a_addr.delete(); a_cyc.delete();
    d_data.delete(); d_eot.delete(); d_cyc.delete();
    k_cyc.delete();
    stab_err = 0;
  endtask

  // Wait for cmd_ready (bounded); leaves time at posedge+1 of the cycle after ack.
  task automatic wait_ack(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL %s ack timeout: no cmd_ready within %0d cycles, required one", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input int base, input int len, input int budget);
    cmd_data  = {8'(len), 16'(base)};
    cmd_valid = 1'b1;
    wait_ack(name, budget);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = {8'd2, 16'd4};
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({cmd_ready, rd_addr_valid, rd_data_ready, dout_valid} !== 4'b0 || dout_data !== 17'h0) begin
      errs++;
      $display("FAIL reset_held: got cr=%b av=%b dr=%b dv=%b dd=%h, required all 0",
               cmd_ready, rd_addr_valid, rd_data_ready, dout_valid, dout_data);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cmd_ready, rd_addr_valid, rd_data_ready, dout_valid} !== 4'b0 || dout_data !== 17'h0) begin
      errs++;
      $display("FAIL reset_after: got cr=%b av=%b dr=%b dv=%b dd=%h, required all 0",
               cmd_ready, rd_addr_valid, rd_data_ready, dout_valid, dout_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_burst();
    clear_logs();
    issue("single", 5, 3, 50);
    vecs++;
    if (a_addr.size() != 4 || d_data.size() != 4 || k_cyc.size() != 1) begin
      errs++;
      $display("FAIL single counts: got addr=%0d dout=%0d ack=%0d, required 4 4 1",
               a_addr.size(), d_data.size(), k_cyc.size());
    end
    for (int i = 0; i < 4 && i < a_addr.size(); i++) begin
      vecs++;
      if (a_addr[i] != 5 + i || a_cyc[i] != a_cyc[0] + i) begin
        errs++;
        $display("FAIL single addr[%0d]: got %0d at +%0d, required %0d at +%0d",
                 i, a_addr[i], a_cyc[i] - a_cyc[0], 5 + i, i);
      end
    end
    for (int i = 0; i < 4 && i < d_data.size(); i++) begin
      vecs++;
      if (d_data[i] !== mem_val(5 + i) || d_eot[i] !== (i == 3)) begin
        errs++;
        $display("FAIL single dout[%0d]: got data=%h eot=%b, required data=%h eot=%b",
                 i, d_data[i], d_eot[i], mem_val(5 + i), (i == 3));
      end
    end
    if (k_cyc.size() == 1 && d_cyc.size() == 4) begin
      vecs++;
      if (k_cyc[0] != d_cyc[3]) begin
        errs++;
        $display("FAIL single ack_cycle: got %0d, required %0d", k_cyc[0], d_cyc[3]);
      end
    end
  endtask

  task automatic test_single_word();
    clear_logs();
    issue("one_word", 0, 0, 50);
    vecs++;
    if (a_addr.size() != 1 || d_data.size() != 1 || k_cyc.size() != 1) begin
      errs++;
      $display("FAIL one_word counts: got addr=%0d dout=%0d ack=%0d, required 1 1 1",
               a_addr.size(), d_data.size(), k_cyc.size());
    end else begin
      vecs++;
      if (a_addr[0] != 0 || d_data[0] !== mem_val(0) || d_eot[0] !== 1'b1 || k_cyc[0] != d_cyc[0]) begin
        errs++;
        $display("FAIL one_word beat: got addr=%0d data=%h eot=%b ack_cyc=%0d, required 0 %h 1 %0d",
                 a_addr[0], d_data[0], d_eot[0], k_cyc[0], mem_val(0), d_cyc[0]);
      end
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    issue("wrap", 14, 3, 50);
    vecs++;
    if (a_addr.size() != 4 || d_data.size() != 4) begin
      errs++;
      $display("FAIL wrap counts: got addr=%0d dout=%0d, required 4 4", a_addr.size(), d_data.size());
    end
    for (int i = 0; i < 4 && i < a_addr.size() && i < d_data.size(); i++) begin
      vecs++;
      if (a_addr[i] != exp_addr(14, i) || d_data[i] !== mem_val(exp_addr(14, i)) || d_eot[i] !== (i == 3)) begin
        errs++;
        $display("FAIL wrap beat[%0d]: got addr=%0d data=%h eot=%b, required %0d %h %b",
                 i, a_addr[i], d_data[i], d_eot[i], exp_addr(14, i), mem_val(exp_addr(14, i)), (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_logs();
    rnd_en = 1'b1;
    issue("bp", 2, 15, 600);
    rnd_en = 1'b0;
    vecs++;
    if (a_addr.size() != 16 || d_data.size() != 16 || k_cyc.size() != 1) begin
      errs++;
      $display("FAIL bp counts: got addr=%0d dout=%0d ack=%0d, required 16 16 1",
               a_addr.size(), d_data.size(), k_cyc.size());
    end
    for (int i = 0; i < 16 && i < a_addr.size() && i < d_data.size(); i++) begin
      vecs++;
      if (a_addr[i] != exp_addr(2, i) || d_data[i] !== mem_val(exp_addr(2, i)) || d_eot[i] !== (i == 15)) begin
        errs++;
        bad++;
        $display("FAIL bp beat[%0d]: got addr=%0d data=%h eot=%b, required %0d %h %b",
                 i, a_addr[i], d_data[i], d_eot[i], exp_addr(2, i), mem_val(exp_addr(2, i)), (i == 15));
      end
    end
    vecs++;
    if (stab_err != 0) begin
      errs++;
      $display("FAIL bp addr_stable: got %0d changes while stalled, required 0", stab_err);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    cmd_data  = {8'd1, 16'd0};
    cmd_valid = 1'b1;
    wait_ack("b2b_first", 50);
    cmd_data = {8'd1, 16'd8};
    wait_ack("b2b_second", 50);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (a_addr.size() != 4 || d_data.size() != 4 || k_cyc.size() != 2) begin
      errs++;
      $display("FAIL b2b counts: got addr=%0d dout=%0d ack=%0d, required 4 4 2",
               a_addr.size(), d_data.size(), k_cyc.size());
    end else begin
      vecs++;
      if (a_addr[0] != 0 || a_addr[1] != 1 || a_addr[2] != 8 || a_addr[3] != 9) begin
        errs++;
        $display("FAIL b2b addrs: got %0d %0d %0d %0d, required 0 1 8 9",
                 a_addr[0], a_addr[1], a_addr[2], a_addr[3]);
      end
      vecs++;
      if (a_cyc[1] - a_cyc[0] != 1 || a_cyc[2] - a_cyc[1] != 2 || a_cyc[3] - a_cyc[2] != 1 ||
          a_cyc[2] != k_cyc[0] + 1) begin
        errs++;
        $display("FAIL b2b timing: got gaps %0d %0d %0d, second start-ack1=%0d, required 1 2 1 and 1",
                 a_cyc[1] - a_cyc[0], a_cyc[2] - a_cyc[1], a_cyc[3] - a_cyc[2], a_cyc[2] - k_cyc[0]);
      end
      vecs++;
      if (d_eot[0] !== 1'b0 || d_eot[1] !== 1'b1 || d_eot[2] !== 1'b0 || d_eot[3] !== 1'b1 ||
          d_data[2] !== mem_val(8) || k_cyc[1] != d_cyc[3]) begin
        errs++;
        $display("FAIL b2b dout: got eot %b%b%b%b data2=%h ack2=%0d, required 0101 %h %0d",
                 d_eot[0], d_eot[1], d_eot[2], d_eot[3], d_data[2], k_cyc[1], mem_val(8), d_cyc[3]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int  seen = 0;
    bit  ok = 1'b0;
    clear_logs();
    cmd_data  = {8'd7, 16'd0};
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_addr_valid && rd_addr_ready) seen++;
      if (seen == 2) begin ok = 1'b1; break; end
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL midrst issue timeout: got %0d addresses, required 2", seen);
    end
    @(posedge clk);
    #1;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cmd_ready, rd_addr_valid, rd_data_ready, dout_valid} !== 4'b0 || dout_data !== 17'h0) begin
      errs++;
      $display("FAIL midrst outputs: got cr=%b av=%b dr=%b dv=%b dd=%h, required all 0",
               cmd_ready, rd_addr_valid, rd_data_ready, dout_valid, dout_data);
    end
    @(posedge clk);
    #1;
    clear_logs();
    issue("midrst_new", 3, 1, 50);
    vecs++;
    if (a_addr.size() != 2 || d_data.size() != 2) begin
      errs++;
      $display("FAIL midrst_new counts: got addr=%0d dout=%0d, required 2 2", a_addr.size(), d_data.size());
    end else begin
      vecs++;
      if (a_addr[0] != 3 || a_addr[1] != 4 || d_eot[0] !== 1'b0 || d_eot[1] !== 1'b1 ||
          d_data[0] !== mem_val(3) || d_data[1] !== mem_val(4)) begin
        errs++;
        $display("FAIL midrst_new beats: got addr %0d %0d eot %b%b data %h %h, required 3 4 01 %h %h",
                 a_addr[0], a_addr[1], d_eot[0], d_eot[1], d_data[0], d_data[1], mem_val(3), mem_val(4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_single_word();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdp_burst_rd.md
# sdp_burst_rd

Burst read sequencer placed directly in front of the `sdp` RAM wrapper. It accepts a burst command (start address, length) and issues consecutive addresses on the RAM's `rd_addr` interface. It collects the returned words from `rd_data` and forwards them downstream with an end-of-transfer flag, forming a pygears-style Queue stream. The command is acknowledged only after the last word of the burst has been consumed.

## Interface
- `W_DATA`, 16, RAM word width; must match the attached `sdp`.
- `W_ADDR`, 16, RAM address width; must match the attached `sdp`.
- `W_LEN`, 8, burst length field width.
- `DEPTH`, 1024, RAM depth; address wrap point, DEPTH ≤ 2^W_ADDR.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset; synchronous and active-high.
- `cmd` dti.consumer W_ADDR+W_LEN: data[W_ADDR-1:0] = base address (< DEPTH); data[W_ADDR+W_LEN-1:W_ADDR] = len, burst is len+1 words.
- `rd_addr` dti.producer W_ADDR: address stream to `sdp` `rd_addr`.
- `rd_data` dti.consumer W_DATA: word stream from `sdp` `rd_data`.
- `dout` dti.producer W_DATA+1: data[W_DATA-1:0] = word; data[W_DATA] = eot.

## Operation
- Registers:
  - `iss_cnt` (W_LEN+1 bits): addresses issued.
  - `ret_cnt` (W_LEN bits): words forwarded.
  - `state` ∈ {IDLE, ISSUE, DRAIN}.
- IDLE: `cmd.ready`=0, `rd_addr.valid`=0. On `cmd.valid`=1, the same cycle behaves as ISSUE (addr valid combinational) and `state` goes to ISSUE.
- ISSUE:
  - `rd_addr.valid`=1.
  - `rd_addr.data` = (base + iss_cnt) wrapped: compute in W_ADDR+1 bits; if result ≥ DEPTH, subtract DEPTH.
  - On `rd_addr` handshake, `iss_cnt`++.
  - When the handshake occurs with iss_cnt == len, the next state is DRAIN.
- DRAIN: `rd_addr.valid`=0; waits for outstanding words.
- Data path, combinational pass-through in ISSUE and DRAIN:
  - `dout.valid` = `rd_data.valid`.
  - `rd_data.ready` = `dout.ready`.
  - eot = (ret_cnt == len).
  - On `dout` handshake, `ret_cnt`++.
- Completion:
  - On the `dout` handshake with eot=1: `cmd.ready`=1 in that same cycle, `ret_cnt`←0, `iss_cnt`←0, `state`←IDLE.
  - `cmd` data is held by the producer until ack and is never registered.
- Data returned and forwarded while addresses are still issuing (ISSUE) is legal; both counters advance independently in the same cycle.
- In IDLE, `rd_data.ready`=0 and `dout.valid`=0. Words arriving without a command are not consumed.
- len=0: single-word burst, eot=1 on the first word.
- Wrap: base=DEPTH-2, len=3 issues DEPTH-2, DEPTH-1, 0, 1.
- base ≥ DEPTH is a protocol violation. The bench asserts on it; RTL behaviour is unspecified.
- Reset mid-burst: all counters clear and state→IDLE on the reset edge. Words still in flight inside `sdp` are the RAM side's responsibility; the system resets `sdp` together with this block.

## Timing
- Reset values (while `rst`=1 and the cycle after): `cmd.ready`=0, `rd_addr.valid`=0, `rd_data.ready`=0, `dout.valid`=0, `dout.data`=0, counters 0, state IDLE.
- cmd.valid → first `rd_addr.valid`: 0 cycles (combinational).
- Peak throughput: one address per cycle and one output word per cycle.
- Burst of N words with no backpressure: N address cycles. The last `dout` beat arrives after the `sdp` read latency, and `cmd.ready` pulses in that beat's cycle.
- Next command: `state` is back in IDLE the cycle after ack, so a held-valid next command issues its first address one cycle after the previous ack. One bubble cycle between bursts.
- `valid` never depends on `ready` on any producer port. `rd_addr.data` is stable while `rd_addr.valid`=1 and `ready`=0.

## Test plan
- Single burst: cmd{base=5,len=3}, no backpressure -> rd_addr 5,6,7,8 on consecutive cycles; dout eot pattern 0,0,0,1 with data = mem[5..8]; one cmd.ready pulse, coincident with the eot beat.
- Single word: cmd{base=0,len=0} -> exactly one rd_addr=0; one dout beat with eot=1 and cmd.ready in the same cycle.
- Wrap: DEPTH=16, cmd{base=14,len=3} -> rd_addr 14,15,0,1; eot set on the 4th word.
- Backpressure: random `dout.ready` (50%) and random `sdp` rd_addr stalls over a len=15 burst -> 16 words in order, no drop or duplicate, `rd_addr.data` stable while stalled, eot only on the 16th word.
- Back-to-back: two cmds held valid, {0,1} then {8,1} -> rd_addr 0,1, then one idle cycle, then 8,9; two eot beats; two cmd.ready pulses.
- Reset mid-burst: assert `rst` after 2 of 8 addresses -> next cycle all outputs 0, state IDLE; a new cmd{base=3,len=1} after reset yields rd_addr 3,4 and eot on the 2nd word.
